// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS instruction-memory side: text segment base,
// memory depth and the image loader's state encoding.
package mips_mem_pkg;

  localparam logic [31:0] TEXT_BASE  = 32'h0040_0000;
  localparam int          IMEM_WORDS = 4096;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_HI,
    LD_LEN_LO,
    LD_DATA,
    LD_WRITE,
    LD_DONE,
    LD_ERROR
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Shift-in register that assembles four stream bytes into one big-endian word;
// the first byte accepted ends up in bits [31:24].
module byte_packer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (shift_en) begin
      word  <= {word[23:0], byte_in};
      count <= count + 2'd1;
    end
  end

  // Flags the byte that completes a word, so the FSM can move to its write cycle.
  assign word_ready = shift_en && (count == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Program-image loader: reads a word-count header and big-endian bytes from the
// host link, writes packed words into instruction memory and holds the CPU until done.
module imem_loader
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TEXT_BASE,
  parameter int          MAX_WORDS = IMEM_WORDS
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  loader_state_t state, next_state;
  logic [7:0]    len_hi;
  logic [15:0]   remaining;
  logic [15:0]   len_n;
  logic          accept;
  logic          start_load;
  logic          shift_en;
  logic          word_ready;
  logic          len_bad;

  assign in_ready = (state == LD_LEN_HI) || (state == LD_LEN_LO) || (state == LD_DATA);
  assign accept   = in_valid && in_ready;
  assign shift_en = accept && (state == LD_DATA);
  assign len_n    = {len_hi, in_data};
  assign len_bad  = (len_n == 16'd0) || ({1'b0, len_n} > MAX_N);

  byte_packer u_packer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (start_load),
    .shift_en   (shift_en),
    .byte_in    (in_data),
    .word       (wr_data),
    .word_ready (word_ready)
  );

  always_comb begin
    next_state = state;
    start_load = 1'b0;
    case (state)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (start) begin
          next_state = LD_LEN_HI;
          start_load = 1'b1;
        end
      end
      LD_LEN_HI: if (accept) next_state = LD_LEN_LO;
      LD_LEN_LO: if (accept) next_state = len_bad ? LD_ERROR : LD_DATA;
      LD_DATA:   if (word_ready) next_state = LD_WRITE;
      LD_WRITE:  next_state = (remaining == 16'd1) ? LD_DONE : LD_DATA;
      default:   next_state = LD_IDLE;
    endcase
  end

  // Status outputs are registered from next_state so they line up with the state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= LD_IDLE;
      len_hi    <= '0;
      remaining <= '0;
      wr_addr   <= BASE_ADDR;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      state    <= next_state;
      wr_en    <= (next_state == LD_WRITE);
      busy     <= (next_state == LD_LEN_HI) || (next_state == LD_LEN_LO) ||
                  (next_state == LD_DATA)   || (next_state == LD_WRITE);
      done     <= (next_state == LD_DONE);
      error    <= (next_state == LD_ERROR);
      cpu_hold <= (next_state != LD_DONE);

      if (start_load) begin
        wr_addr <= BASE_ADDR;
      end else if (state == LD_WRITE) begin
        wr_addr   <= wr_addr + 32'd4;
        remaining <= remaining - 16'd1;
      end

      if (accept && (state == LD_LEN_HI)) len_hi <= in_data;
      if (accept && (state == LD_LEN_LO)) remaining <= len_n;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: a byte-level model predicts
// the memory write sequence, status flags and load latency for each image.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int          MAXW = 4096;

  logic        clock    = 1'b0;
  logic        reset_n  = 1'b0;
  logic        start    = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data  = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_hold (cpu_hold)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          t0    = 0;
  bit          arm_t0 = 1'b0;
  bit          arm_after_start = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [7:0]  data_bytes[$];
  logic [63:0] e;

  always @(posedge clock) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, req);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  // Compare process: every observed write must match the next predicted one.
  always @(negedge clock) begin
    if (arm_t0 && in_ready) begin
      t0     = cyc;
      arm_t0 = 1'b0;
    end
    if (arm_after_start) begin
      arm_after_start = 1'b0;
      checkBit("busy_after_start", busy, 1'b1);
      checkBit("done_clear", done, 1'b0);
      checkBit("error_clear", error, 1'b0);
      checkBit("in_ready_after_start", in_ready, 1'b1);
    end
    if (reset_n && wr_en) begin
      obs_q.push_back({wr_addr, wr_data});
      checkBit("in_ready_in_write", in_ready, 1'b0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: got 0x%08h @0x%08h want none", wr_data, wr_addr);
      end else begin
        e = exp_q.pop_front();
        checkOutput("wr_addr", wr_addr, e[63:32]);
        checkOutput("wr_data", wr_data, e[31:0]);
      end
    end
  end

  task automatic resetChecks(input string tag);
    checkBit({tag, "_cpu_hold"}, cpu_hold, 1'b1);
    checkOutput({tag, "_wr_addr"}, wr_addr, BASE);
    checkOutput({tag, "_wr_data"}, wr_data, 32'h0);
    checkBit({tag, "_in_ready"}, in_ready, 1'b0);
    checkBit({tag, "_wr_en"}, wr_en, 1'b0);
    checkBit({tag, "_busy"}, busy, 1'b0);
    checkBit({tag, "_done"}, done, 1'b0);
    checkBit({tag, "_error"}, error, 1'b0);
  endtask

  // Presents one byte (after an optional idle gap) and returns just after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int guard;
    if (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat ($urandom_range(3, 1)) begin
        @(posedge clock);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    forever begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        break;
      end
      guard++;
      if (guard > 50) begin
        checkBit("accept_timeout", 1'b0, 1'b1);
        @(posedge clock);
        #1;
        break;
      end
    end
  endtask

  // One complete load of an n-word image; data comes from data_bytes first, then random.
  task automatic applyStimulus(input logic [15:0] n, input int gap_pct, input bit start_mid);
    logic [7:0]  bytes[$];
    logic [31:0] w;
    bit          good;
    int          guard;
    int          t1;
    good = (n != 16'd0) && (int'(n) <= MAXW);
    bytes.push_back(n[15:8]);
    bytes.push_back(n[7:0]);
    if (good) begin
      for (int i = 0; i < 4 * int'(n); i++)
        bytes.push_back((data_bytes.size() > 0) ? data_bytes.pop_front() : 8'($urandom));
      for (int i = 0; i < int'(n); i++) begin
        w = {bytes[2 + 4*i], bytes[3 + 4*i], bytes[4 + 4*i], bytes[5 + 4*i]};
        exp_q.push_back({BASE + 32'(4 * i), w});
      end
    end
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    arm_after_start = 1'b1;
    arm_t0 = 1'b1;
    for (int k = 0; k < bytes.size(); k++) begin
      send_byte(bytes[k], gap_pct);
      if (start_mid && k == 3) begin
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
    guard = 0;
    forever begin
      @(negedge clock);
      if (done || error) break;
      guard++;
      if (guard > 100) begin
        checkBit("finish_timeout", 1'b0, 1'b1);
        break;
      end
    end
    t1 = cyc;
    if (gap_pct == 0 && !start_mid)
      checkOutput("latency", 32'(t1 - t0), good ? 32'(2 + 5 * int'(n)) : 32'd2);
    checkBit("done", done, good);
    checkBit("error", error, !good);
    checkBit("cpu_hold", cpu_hold, !good);
    checkBit("busy_end", busy, 1'b0);
    checkOutput("writes_left", 32'(exp_q.size()), 32'd0);
    checkOutput("final_addr", wr_addr, good ? BASE + 32'(4 * int'(n)) : BASE);
    exp_q.delete();
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    resetChecks("por");
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Directed image with hand-computed writes.
    obs_q.delete();
    data_bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    applyStimulus(16'd2, 0, 1'b0);
    checkOutput("lit_nwrites", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      checkOutput("lit_addr0", obs_q[0][63:32], 32'h0040_0000);
      checkOutput("lit_data0", obs_q[0][31:0], 32'h2008_0005);
      checkOutput("lit_addr1", obs_q[1][63:32], 32'h0040_0004);
      checkOutput("lit_data1", obs_q[1][31:0], 32'h0109_5020);
    end

    // Restart from DONE with gaps and an ignored start mid-data.
    applyStimulus(16'd3, 40, 1'b1);

    // Bad headers: zero and one past the limit.
    applyStimulus(16'd0, 0, 1'b0);
    applyStimulus(16'd4097, 0, 1'b0);

    for (int r = 0; r < 5; r++)
      applyStimulus(16'($urandom_range(6, 1)), int'($urandom_range(60, 0)), 1'($urandom_range(1, 0)));

    // Reset in the middle of a word; only post-restart bytes may reach memory.
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    resetChecks("midload");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    obs_q.delete();
    data_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
    applyStimulus(16'd1, 0, 1'b0);
    checkOutput("restart_nwrites", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1)
      checkOutput("restart_word", obs_q[0][31:0], 32'h1234_5678);

    // Largest legal image.
    obs_q.delete();
    applyStimulus(16'd4096, 0, 1'b0);
    if (obs_q.size() > 0)
      checkOutput("last_addr", obs_q[obs_q.size() - 1][63:32], 32'h0040_3FFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writes a program image into the instruction memory before the processor starts fetching. The loader sits between a byte-stream source (host link) and the instruction memory's write side: it accepts a length header and big-endian instruction bytes over a valid/ready handshake, then packs them into 32-bit words. It issues one word write per packed word at consecutive byte addresses from the text base, and holds the CPU until the image is complete.

## Interface

Parameters:
- BASE_ADDR, 32'h00400000, byte address of first word written (text segment base).
- MAX_WORDS, 4096, largest accepted word count.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR; ignored while busy.
- in_valid  in  1  source has a byte on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; transfer when in_valid && in_ready.
- wr_en  out  1  one-cycle memory write strobe.
- wr_addr  out  32  byte address of write, word-aligned.
- wr_data  out  32  word to write.
- busy  out  1  load in progress.
- done  out  1  image fully written; sticky until next start.
- error  out  1  bad header; sticky until next start.
- cpu_hold  out  1  keeps PC register/CPU stalled; low only in DONE.

One clock; reset is asynchronous and active-low (clock, reset_n).

## Operation

- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
- IDLE: start -> LEN_HI; clear done/error; wr_addr <= BASE_ADDR.
- LEN_HI / LEN_LO: accept two bytes, word count N = {hi, lo} (16 bits, unsigned).
- After LEN_LO transfer: N == 0 or N > MAX_WORDS -> ERROR; else -> DATA, remaining <= N.
- DATA: accept bytes into shift register, first byte -> wr_data[31:24] (big-endian, MIPS order); 2-bit byte counter. On 4th transfer -> WRITE.
- WRITE: wr_en = 1 for exactly one cycle with wr_addr/wr_data stable; in_ready = 0. Next cycle wr_addr += 4, remaining -= 1; remaining becomes 0 -> DONE, else -> DATA.
- DONE: done = 1, cpu_hold = 0, busy = 0. ERROR: error = 1, cpu_hold = 1, busy = 0.
- start in DONE or ERROR restarts identical to IDLE; start in any busy state ignored.
- Address arithmetic 32-bit unsigned; last address written = BASE_ADDR + 4*(N-1); no wrap possible given MAX_WORDS.
- in_valid without in_ready: byte not consumed, no state change.

## Timing

- Reset values: in_ready 0, wr_en 0, wr_addr BASE_ADDR, wr_data 0, busy 0, done 0, error 0, cpu_hold 1; state IDLE.
- All outputs registered except in_ready (decoded from state: 1 in LEN_HI, LEN_LO, DATA).
- start at edge k -> in_ready high from cycle k+1.
- With in_valid held high: 2 header cycles, then 5 cycles per word (4 bytes + 1 WRITE); N words -> done high 2 + 5N cycles after first in_ready.
- busy = 1 in LEN_HI, LEN_LO, DATA, WRITE.
- reset_n low mid-load: immediate return to reset values; partial word discarded; memory contents already written untouched.
- Backpressure: source may drop in_valid any cycle; byte counter holds.

## Structure

- Shared package mips_mem_pkg: TEXT_BASE (32'h00400000), IMEM_WORDS (4096), loader state enum.
- Sub-module byte_packer: shift-in register + 2-bit counter, outputs word and word_ready; FSM in imem_loader.

## Test plan

- Reset: reset_n low -> cpu_hold 1, wr_addr 0x00400000, in_ready 0, done 0.
- Load N=2, bytes 00 02, 20 08 00 05, 01 09 50 20 -> writes 0x20080005 @0x00400000, 0x01095020 @0x00400004, done 1, cpu_hold 0, total 12 cycles with continuous valid.
- Header 00 00 -> error 1, no wr_en, cpu_hold 1; header 10 01 (4097) -> error 1.
- Random in_valid gaps during N=3 load -> same write sequence/data, no dropped or duplicated bytes.
- reset_n low after 2 data bytes, then start, N=1 -> single write at 0x00400000 with only post-restart bytes.
- start pulsed during DATA -> ignored; start in DONE -> fresh load, done clears next cycle.
